tron_player: RTL and testbench

TRON_PLAYER -- requirements
Module: tron_player

---
 rtl/tron_player.sv | 158 +++++++++++++++
 tb/tb_tron_player.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tron_player.sv
// Light-cycle player head: paces grid steps off frame_tick, probes the trail
// memory for the next cell, then either commits the move or crashes.
module tron_player #(
  parameter int unsigned START_X   = 10,
  parameter int unsigned START_Y   = 30,
  parameter logic [2:0]  START_DIR = 3'b011,
  parameter int unsigned MOVE_DIV  = 4,
  parameter int unsigned GRID_W    = 80,
  parameter int unsigned GRID_H    = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [2:0] dir_req,
  input  logic       go,
  input  logic       trail_hit,
  output logic [6:0] pos_x,
  output logic [5:0] pos_y,
  output logic [2:0] dir,
  output logic [6:0] probe_x,
  output logic [5:0] probe_y,
  output logic       trail_we,
  output logic [6:0] trail_x,
  output logic [5:0] trail_y,
  output logic       alive,
  output logic       crashed
);

  typedef enum logic [2:0] {UP = 3'd0, DOWN = 3'd1, LEFT = 3'd2, RIGHT = 3'd3, STOP = 3'd4} player_dir_t;
  typedef enum logic [2:0] {IDLE, RUN, PROBE, CHECK, CRASH} state_t;

  localparam logic [6:0] SX = 7'(START_X);
  localparam logic [5:0] SY = 6'(START_Y);
  localparam logic [3:0] CNT_LAST = 4'(MOVE_DIV - 1);

  state_t     state_q, state_d;
  logic [6:0] pos_x_q, pos_x_d, trail_x_q, trail_x_d;
  logic [5:0] pos_y_q, pos_y_d, trail_y_q, trail_y_d;
  logic [2:0] dir_q, dir_d, pend_q, pend_d;
  logic [3:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic [6:0] next_x;
  logic [5:0] next_y;
  logic       dir_ok, border;

  // Neighbour cell in the pending heading; pos stays inside the border so no wrap.
  always_comb begin
    next_x = pos_x_q;
    next_y = pos_y_q;
    case (pend_q)
      UP:      next_y = pos_y_q - 6'd1;
      DOWN:    next_y = pos_y_q + 6'd1;
      LEFT:    next_x = pos_x_q - 7'd1;
      RIGHT:   next_x = pos_x_q + 7'd1;
      default: ;
    endcase
  end

  // Only real headings that are not a direct reversal of the current heading.
  assign dir_ok = (dir_req <= RIGHT) && (dir_req != {dir_q[2:1], ~dir_q[0]});
  assign border = (next_x == 7'd0) || (next_x == 7'(GRID_W - 1)) ||
                  (next_y == 6'd0) || (next_y == 6'(GRID_H - 1));

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    trail_x_d = trail_x_q;
    trail_y_d = trail_y_q;
    case (state_q)
      IDLE: if (go) begin
        state_d   = RUN;
        we_d      = 1'b1;
        trail_x_d = SX;
        trail_y_d = SY;
        cnt_d     = '0;
      end
      RUN: begin
        if (dir_ok) pend_d = dir_req;
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = PROBE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      PROBE: begin
        dir_d   = pend_q;
        state_d = CHECK;
      end
      CHECK: begin
        if (trail_hit || border) begin
          state_d = CRASH;
        end else begin
          pos_x_d   = next_x;
          pos_y_d   = next_y;
          we_d      = 1'b1;
          trail_x_d = next_x;
          trail_y_d = next_y;
          state_d   = RUN;
        end
      end
      CRASH: if (go) begin
        state_d = IDLE;
        pos_x_d = SX;
        pos_y_d = SY;
        dir_d   = START_DIR;
        pend_d  = START_DIR;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pos_x_q   <= SX;
      pos_y_q   <= SY;
      dir_q     <= START_DIR;
      pend_q    <= START_DIR;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      trail_x_q <= SX;
      trail_y_q <= SY;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      trail_x_q <= trail_x_d;
      trail_y_q <= trail_y_d;
    end
  end

  // Probe address is live from PROBE onward so trail_hit lands in CHECK; it
  // keeps pointing at the fatal cell while crashed.
  assign probe_x  = (state_q == PROBE || state_q == CHECK || state_q == CRASH) ? next_x : pos_x_q;
  assign probe_y  = (state_q == PROBE || state_q == CHECK || state_q == CRASH) ? next_y : pos_y_q;
  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign dir      = dir_q;
  assign trail_we = we_q;
  assign trail_x  = trail_x_q;
  assign trail_y  = trail_y_q;
  assign alive    = (state_q == RUN);
  assign crashed  = (state_q == CRASH);

endmodule

// File: tb/tb_tron_player.sv
// Directed bench for tron_player: default instance plus a border-start instance.
module tb_tron_player;

  logic       clock = 1'b0;
  logic       reset = 1'b1, frame_tick = 1'b0, go = 1'b0, trail_hit = 1'b0;
  logic [2:0] dir_req = 3'd3;
  logic [6:0] pos_x, probe_x, trail_x;
  logic [5:0] pos_y, probe_y, trail_y;
  logic [2:0] dir;
  logic       trail_we, alive, crashed;

  logic       reset_b = 1'b1, tick_b = 1'b0, go_b = 1'b0, hit_b = 1'b0;
  logic [2:0] dir_req_b = 3'd3;
  logic [6:0] pos_x_b, probe_x_b, trail_x_b;
  logic [5:0] pos_y_b, probe_y_b, trail_y_b;
  logic [2:0] dir_b;
  logic       trail_we_b, alive_b, crashed_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  tron_player dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .dir_req(dir_req), .go(go),
    .trail_hit(trail_hit), .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .probe_x(probe_x),
    .probe_y(probe_y), .trail_we(trail_we), .trail_x(trail_x), .trail_y(trail_y),
    .alive(alive), .crashed(crashed)
  );

  tron_player #(.START_X(78), .MOVE_DIV(1)) dut_b (
    .clock(clock), .reset(reset_b), .frame_tick(tick_b), .dir_req(dir_req_b), .go(go_b),
    .trail_hit(hit_b), .pos_x(pos_x_b), .pos_y(pos_y_b), .dir(dir_b), .probe_x(probe_x_b),
    .probe_y(probe_y_b), .trail_we(trail_we_b), .trail_x(trail_x_b), .trail_y(trail_y_b),
    .alive(alive_b), .crashed(crashed_b)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One full step of div ticks (one idle cycle between ticks), ending on the commit cycle.
  task automatic run_step(input int div);
    for (int i = 0; i < div; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      if (i < div - 1) cyc();
    end
    cyc(); cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc();
    n_tests++;
    if ({pos_x, pos_y, dir} !== {7'd10, 6'd30, 3'd3}) begin
      n_fail++; $display("FAIL reset_pos_dir: got x=%0d y=%0d dir=%0d want 10 30 3", pos_x, pos_y, dir);
    end
    n_tests++;
    if ({trail_we, alive, crashed, probe_x, probe_y} !== {3'b000, 7'd10, 6'd30}) begin
      n_fail++; $display("FAIL reset_flags: got we=%b alive=%b crashed=%b probe=%0d,%0d want 0 0 0 10,30",
                         trail_we, alive, crashed, probe_x, probe_y);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    n_tests++;
    if (alive !== 1'b0 || trail_we !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: got alive=%b we=%b want 0 0", alive, trail_we);
    end
  endtask

  task automatic test_straight_run();
    int ex = 10;
    go = 1'b1; dir_req = 3'd3; cyc(); go = 1'b0;
    n_tests++;
    if ({trail_we, alive, trail_x, trail_y} !== {2'b11, 7'd10, 6'd30}) begin
      n_fail++; $display("FAIL go_write: got we=%b alive=%b at %0d,%0d want 1 1 at 10,30",
                         trail_we, alive, trail_x, trail_y);
    end
    for (int t = 1; t <= 8; t++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      if (t % 4 == 0) begin
        n_tests++;
        if (alive !== 1'b0 || pos_x !== 7'(ex) || trail_we !== 1'b0) begin
          n_fail++; $display("FAIL run_probe_%0d: got alive=%b x=%0d we=%b want 0 %0d 0", t, alive, pos_x, trail_we, ex);
        end
        cyc();
        n_tests++;
        if (probe_x !== 7'(ex + 1) || probe_y !== 6'd30 || pos_x !== 7'(ex) || trail_we !== 1'b0) begin
          n_fail++; $display("FAIL run_check_%0d: got probe=%0d,%0d x=%0d we=%b want %0d,30 %0d 0",
                             t, probe_x, probe_y, pos_x, trail_we, ex + 1, ex);
        end
        cyc();
        ex++;
        n_tests++;
        if ({pos_x, pos_y, trail_we, trail_x, trail_y, alive} !== {7'(ex), 6'd30, 1'b1, 7'(ex), 6'd30, 1'b1}) begin
          n_fail++; $display("FAIL run_commit_%0d: got pos=%0d,%0d we=%b trail=%0d,%0d alive=%b want %0d,30 1 %0d,30 1",
                             t, pos_x, pos_y, trail_we, trail_x, trail_y, alive, ex, ex);
        end
      end else begin
        n_tests++;
        if (alive !== 1'b1 || pos_x !== 7'(ex) || trail_we !== 1'b0) begin
          n_fail++; $display("FAIL run_wait_%0d: got alive=%b x=%0d we=%b want 1 %0d 0", t, alive, pos_x, trail_we, ex);
        end
        cyc();
      end
    end
  endtask

  task automatic test_reversal();
    reset = 1'b1; cyc(); reset = 1'b0;
    go = 1'b1; cyc(); go = 1'b0;
    dir_req = 3'd2;
    run_step(4);
    n_tests++;
    if ({pos_x, pos_y, dir} !== {7'd11, 6'd30, 3'd3}) begin
      n_fail++; $display("FAIL reverse_reject: got %0d,%0d dir=%0d want 11,30 dir=3", pos_x, pos_y, dir);
    end
    dir_req = 3'd0;
    run_step(4);
    dir_req = 3'd4;
    n_tests++;
    if ({pos_x, pos_y, dir, trail_we} !== {7'd11, 6'd29, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL turn_up: got %0d,%0d dir=%0d we=%b want 11,29 dir=0 we=1", pos_x, pos_y, dir, trail_we);
    end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      if (i < 3) cyc();
    end
    cyc();
    n_tests++;
    if (probe_x !== 7'd11 || probe_y !== 6'd28) begin
      n_fail++; $display("FAIL hit_probe: got %0d,%0d want 11,28", probe_x, probe_y);
    end
    trail_hit = 1'b1; cyc(); trail_hit = 1'b0;
    n_tests++;
    if ({crashed, alive, trail_we, pos_x, pos_y} !== {3'b100, 7'd11, 6'd29}) begin
      n_fail++; $display("FAIL hit_crash: got crashed=%b alive=%b we=%b pos=%0d,%0d want 1 0 0 11,29",
                         crashed, alive, trail_we, pos_x, pos_y);
    end
    frame_tick = 1'b1; cyc(); cyc(); frame_tick = 1'b0; cyc();
    n_tests++;
    if ({crashed, trail_we, pos_x, pos_y, probe_x, probe_y} !== {2'b10, 7'd11, 6'd29, 7'd11, 6'd28}) begin
      n_fail++; $display("FAIL crash_hold: got crashed=%b we=%b pos=%0d,%0d probe=%0d,%0d want 1 0 11,29 11,28",
                         crashed, trail_we, pos_x, pos_y, probe_x, probe_y);
    end
  endtask

  task automatic test_restart_dropped();
    go = 1'b1; cyc(); go = 1'b0;
    n_tests++;
    if ({crashed, alive, pos_x, pos_y, dir, probe_x, probe_y} !== {2'b00, 7'd10, 6'd30, 3'd3, 7'd10, 6'd30}) begin
      n_fail++; $display("FAIL restart_idle: got crashed=%b alive=%b pos=%0d,%0d dir=%0d probe=%0d,%0d want 0 0 10,30 3 10,30",
                         crashed, alive, pos_x, pos_y, dir, probe_x, probe_y);
    end
    cyc();
    go = 1'b1; cyc(); go = 1'b0;
    n_tests++;
    if ({trail_we, alive, trail_x, trail_y} !== {2'b11, 7'd10, 6'd30}) begin
      n_fail++; $display("FAIL restart_go: got we=%b alive=%b at %0d,%0d want 1 1 at 10,30", trail_we, alive, trail_x, trail_y);
    end
    go = 1'b1; cyc(); go = 1'b0;
    n_tests++;
    if (trail_we !== 1'b0 || alive !== 1'b1) begin
      n_fail++; $display("FAIL go_in_run: got we=%b alive=%b want 0 1", trail_we, alive);
    end
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      if (i < 3) cyc();
    end
    frame_tick = 1'b1; cyc(); cyc(); frame_tick = 1'b0;
    n_tests++;
    if (pos_x !== 7'd11 || alive !== 1'b1) begin
      n_fail++; $display("FAIL dropped_commit: got x=%0d alive=%b want 11 1", pos_x, alive);
    end
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      n_tests++;
      if (alive !== 1'b1) begin
        n_fail++; $display("FAIL dropped_tick_%0d: got alive=%b want 1", i, alive);
      end
      cyc();
    end
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    n_tests++;
    if (alive !== 1'b0) begin
      n_fail++; $display("FAIL fourth_tick_probe: got alive=%b want 0", alive);
    end
    cyc(); cyc();
    n_tests++;
    if (pos_x !== 7'd12 || trail_we !== 1'b1) begin
      n_fail++; $display("FAIL second_commit: got x=%0d we=%b want 12 1", pos_x, trail_we);
    end
  endtask

  task automatic test_reset_mid_step();
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      if (i < 3) cyc();
    end
    cyc();
    reset = 1'b1; #1;
    n_tests++;
    if ({alive, crashed, trail_we, pos_x, pos_y, dir, probe_x, probe_y} !== {3'b000, 7'd10, 6'd30, 3'd3, 7'd10, 6'd30}) begin
      n_fail++; $display("FAIL async_reset: got alive=%b crashed=%b we=%b pos=%0d,%0d dir=%0d probe=%0d,%0d want 0 0 0 10,30 3 10,30",
                         alive, crashed, trail_we, pos_x, pos_y, dir, probe_x, probe_y);
    end
    cyc(); reset = 1'b0; cyc(); cyc();
    n_tests++;
    if (alive !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got alive=%b want 0", alive);
    end
    go = 1'b1; cyc(); go = 1'b0;
    n_tests++;
    if ({trail_we, trail_x, trail_y} !== {1'b1, 7'd10, 6'd30}) begin
      n_fail++; $display("FAIL post_reset_go: got we=%b at %0d,%0d want 1 at 10,30", trail_we, trail_x, trail_y);
    end
  endtask

  task automatic test_border();
    reset_b = 1'b1; cyc(); reset_b = 1'b0; cyc();
    go_b = 1'b1; cyc(); go_b = 1'b0;
    n_tests++;
    if ({trail_we_b, trail_x_b, trail_y_b} !== {1'b1, 7'd78, 6'd30}) begin
      n_fail++; $display("FAIL border_go: got we=%b at %0d,%0d want 1 at 78,30", trail_we_b, trail_x_b, trail_y_b);
    end
    tick_b = 1'b1; cyc(); tick_b = 1'b0;
    n_tests++;
    if (alive_b !== 1'b0) begin
      n_fail++; $display("FAIL border_probe_state: got alive=%b want 0", alive_b);
    end
    cyc();
    n_tests++;
    if (probe_x_b !== 7'd79 || probe_y_b !== 6'd30) begin
      n_fail++; $display("FAIL border_probe: got %0d,%0d want 79,30", probe_x_b, probe_y_b);
    end
    cyc();
    n_tests++;
    if ({crashed_b, trail_we_b, pos_x_b, pos_y_b} !== {2'b10, 7'd78, 6'd30}) begin
      n_fail++; $display("FAIL border_crash: got crashed=%b we=%b pos=%0d,%0d want 1 0 78,30",
                         crashed_b, trail_we_b, pos_x_b, pos_y_b);
    end
  endtask

  initial begin
    test_reset();
    test_straight_run();
    test_reversal();
    test_collision();
    test_restart_dropped();
    test_reset_mid_step();
    test_border();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
